// File: rtl/sta_pkg.sv
// Shared constants and types for the systolic tensor array result path.
package sta_pkg;

  localparam int unsigned QUANTIZED_WIDTH   = 8;
  localparam int unsigned ACCUMULATOR_WIDTH = 4 * QUANTIZED_WIDTH;
  localparam int unsigned PE_RESULT_WIDTH   = 4 * ACCUMULATOR_WIDTH;
  localparam int unsigned LANES_PER_PE      = 4;

  typedef enum logic {
    IDLE,
    STREAM
  } drain_state_t;

endpackage

// File: rtl/sta_drain_index.sv
// Row-major lane/col/row beat counter for the result drain.
// Lane is innermost; it carries into column, and column carries into row.
module sta_drain_index
  import sta_pkg::*;
#(
  parameter int unsigned M    = 2,
  parameter int unsigned N    = 2,
  parameter int unsigned RowW = (M > 1) ? $clog2(M) : 1,
  parameter int unsigned ColW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            advance_i,
  input  logic            clear_i,
  output logic [RowW-1:0] row_o,
  output logic [ColW-1:0] col_o,
  output logic [1:0]      lane_o,
  output logic            last_o
);

  localparam logic [RowW-1:0] RowMax  = RowW'(M - 1);
  localparam logic [ColW-1:0] ColMax  = ColW'(N - 1);
  localparam logic [1:0]      LaneMax = 2'(LANES_PER_PE - 1);

  logic [RowW-1:0] row_q;
  logic [ColW-1:0] col_q;
  logic [1:0]      lane_q;
  logic            lane_wrap;
  logic            col_wrap;
  logic            row_wrap;

  assign lane_wrap = (lane_q == LaneMax);
  assign col_wrap  = (col_q == ColMax);
  assign row_wrap  = (row_q == RowMax);

  // Clear wins over advance so a back-to-back capture restarts at beat 0.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      row_q  <= '0;
      col_q  <= '0;
      lane_q <= '0;
    end else if (clear_i) begin
      row_q  <= '0;
      col_q  <= '0;
      lane_q <= '0;
    end else if (advance_i) begin
      if (lane_wrap) begin
        lane_q <= '0;
        if (col_wrap) begin
          col_q <= '0;
          row_q <= row_wrap ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end else begin
        lane_q <= lane_q + 1'b1;
      end
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign lane_o = lane_q;
  assign last_o = lane_wrap && col_wrap && row_wrap;

endmodule

// File: rtl/sta_result_drain.sv
// Snapshots the STA result grid and streams it out one accumulator lane per beat,
// freeing the array for the next tile while the previous one drains.
module sta_result_drain
  import sta_pkg::*;
#(
  parameter int unsigned N                 = 2,
  parameter int unsigned M                 = 2,
  parameter int unsigned QUANTIZED_WIDTH   = 8,
  parameter int unsigned ACCUMULATOR_WIDTH = 4 * QUANTIZED_WIDTH,
  parameter int unsigned PE_RESULT_WIDTH   = 4 * ACCUMULATOR_WIDTH
) (
  input  logic                                            clk_i,
  input  logic                                            reset_i,
  input  logic signed [M-1:0][N-1:0][PE_RESULT_WIDTH-1:0] result_i,
  input  logic                                            capture_i,
  output logic                                            out_valid_o,
  input  logic                                            out_ready_i,
  output logic signed [ACCUMULATOR_WIDTH-1:0]             out_data_o,
  output logic [((M > 1) ? $clog2(M) : 1)-1:0]            out_row_o,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]            out_col_o,
  output logic [1:0]                                      out_lane_o,
  output logic                                            out_last_o,
  output logic                                            busy_o,
  output logic                                            capture_drop_o
);

  localparam int unsigned RowW = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned ColW = (N > 1) ? $clog2(N) : 1;

  drain_state_t                            state_q;
  logic [M-1:0][N-1:0][PE_RESULT_WIDTH-1:0] shadow_q;
  logic                                    drop_q;

  logic [RowW-1:0]              row;
  logic [ColW-1:0]              col;
  logic [1:0]                   lane;
  logic                         last;
  logic                         busy;
  logic                         handshake;
  logic                         last_hs;
  logic                         take;
  logic [PE_RESULT_WIDTH-1:0]   pe_word;
  logic [ACCUMULATOR_WIDTH-1:0] lane_word;

  assign busy      = (state_q == STREAM);
  assign handshake = busy && out_ready_i;
  assign last_hs   = handshake && last;
  // A capture is accepted when idle, or when the final beat is leaving this cycle.
  assign take      = capture_i && (!busy || last_hs);

  // Drain FSM: snapshot on accepted capture, flag rejected captures.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (capture_i) begin
            shadow_q <= result_i;
            state_q  <= STREAM;
          end
        end
        STREAM: begin
          if (last_hs) begin
            if (capture_i) begin
              shadow_q <= result_i;
            end else begin
              state_q <= IDLE;
            end
          end else if (capture_i) begin
            drop_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sta_drain_index #(
    .M    (M),
    .N    (N),
    .RowW (RowW),
    .ColW (ColW)
  ) u_index (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .advance_i (handshake),
    .clear_i   (take),
    .row_o     (row),
    .col_o     (col),
    .lane_o    (lane),
    .last_o    (last)
  );

  // Lane select from the held snapshot; lane 0 is the least significant word.
  always_comb begin
    pe_word   = shadow_q[row][col];
    lane_word = '0;
    for (int unsigned l = 0; l < LANES_PER_PE; l++) begin
      if (lane == 2'(l)) begin
        lane_word = pe_word[l*ACCUMULATOR_WIDTH +: ACCUMULATOR_WIDTH];
      end
    end
  end

  // Outputs are zero whenever no beat is being offered.
  always_comb begin
    out_valid_o    = busy;
    out_data_o     = busy ? lane_word : '0;
    out_row_o      = busy ? row : '0;
    out_col_o      = busy ? col : '0;
    out_lane_o     = busy ? lane : '0;
    out_last_o     = busy && last;
    busy_o         = busy;
    capture_drop_o = drop_q;
  end

endmodule

// File: tb/tb_sta_result_drain.sv
// Directed bench for sta_result_drain at the default 2x2 geometry.
module tb_sta_result_drain;

  logic                         clk_i = 1'b0;
  logic                         reset_i;
  logic signed [1:0][1:0][127:0] result_i;
  logic                         capture_i;
  logic                         out_valid_o;
  logic                         out_ready_i;
  logic signed [31:0]           out_data_o;
  logic [0:0]                   out_row_o;
  logic [0:0]                   out_col_o;
  logic [1:0]                   out_lane_o;
  logic                         out_last_o;
  logic                         busy_o;
  logic                         capture_drop_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] tile   [16];
  logic [31:0] tile_b [16];

  logic [39:0] all_outs;
  logic [37:0] beat_got;
  logic [37:0] beat_exp;

  assign all_outs = {out_valid_o, out_data_o, out_row_o, out_col_o, out_lane_o,
                     out_last_o, busy_o, capture_drop_o};
  assign beat_got = {out_valid_o, out_last_o, out_row_o, out_col_o, out_lane_o, out_data_o};

  always #5 clk_i = ~clk_i;

  sta_result_drain dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .result_i       (result_i),
    .capture_i      (capture_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_data_o     (out_data_o),
    .out_row_o      (out_row_o),
    .out_col_o      (out_col_o),
    .out_lane_o     (out_lane_o),
    .out_last_o     (out_last_o),
    .busy_o         (busy_o),
    .capture_drop_o (capture_drop_o)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Beat b maps to row b[3], col b[2], lane b[1:0].
  task automatic drive_tile(input bit alt);
    for (int b = 0; b < 16; b++) begin
      result_i[b >> 3][(b >> 2) & 1][(b & 3) * 32 +: 32] = alt ? tile_b[b] : tile[b];
    end
  endtask

  task automatic test_reset();
    reset_i     = 1'b1;
    capture_i   = 1'b0;
    out_ready_i = 1'b0;
    result_i    = '0;
    repeat (2) @(negedge clk_i);
    n_checks++;
    if (all_outs !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", all_outs);
    end
    for (int b = 0; b < 16; b++) tile[b] = 32'h5A5A_0000 | 32'(b);
    drive_tile(0);
    out_ready_i = 1'b1;
    reset_i     = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      n_checks++;
      if (all_outs !== 40'd0) begin
        n_fail++;
        $display("FAIL idle_outputs cycle %0d: got %h want 0", c, all_outs);
      end
    end
  endtask

  task automatic test_full_drain();
    for (int b = 0; b < 16; b++) tile[b] = 32'((b >> 3) << 8 | ((b >> 2) & 1) << 4 | (b & 3));
    drive_tile(0);
    out_ready_i = 1'b1;
    capture_i   = 1'b1;
    @(negedge clk_i);
    capture_i = 1'b0;
    for (int b = 0; b < 16; b++) begin
      beat_exp = {1'b1, (b == 15), 4'(b), tile[b]};
      n_checks++;
      if (beat_got !== beat_exp) begin
        n_fail++;
        $display("FAIL full_drain beat %0d: got %h want %h", b, beat_got, beat_exp);
      end
      @(negedge clk_i);
    end
    n_checks++;
    if ({busy_o, out_valid_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL full_drain_done: got busy/valid %b want 00", {busy_o, out_valid_o});
    end
  endtask

  task automatic test_backpressure();
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int b = 0;
    for (int k = 0; k < 16; k++) begin
      tile[k] = (k & 1) ? 32'(127 + (k << 8)) : 32'(-128 - (k << 8));
    end
    drive_tile(0);
    out_ready_i = 1'b0;
    capture_i   = 1'b1;
    @(negedge clk_i);
    capture_i = 1'b0;
    for (int cyc = 0; cyc < 100 && b < 16; cyc++) begin
      out_ready_i = pat[cyc % 4];
      beat_exp = {1'b1, (b == 15), 4'(b), tile[b]};
      n_checks++;
      if (beat_got !== beat_exp) begin
        n_fail++;
        $display("FAIL backpressure cycle %0d beat %0d: got %h want %h", cyc, b, beat_got,
                 beat_exp);
      end
      if (out_ready_i) b++;
      @(negedge clk_i);
    end
    n_checks++;
    if (b != 16 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_done: got beats %0d busy %b want 16 0", b, busy_o);
    end
    out_ready_i = 1'b1;
  endtask

  task automatic test_capture_busy();
    for (int b = 0; b < 16; b++) begin
      tile[b]   = 32'hA000_0000 | 32'(b);
      tile_b[b] = 32'hB000_0000 | 32'(b);
    end
    drive_tile(0);
    out_ready_i = 1'b1;
    capture_i   = 1'b1;
    @(negedge clk_i);
    capture_i = 1'b0;
    for (int b = 0; b < 16; b++) begin
      beat_exp = {1'b1, (b == 15), 4'(b), tile[b]};
      n_checks++;
      if (beat_got !== beat_exp) begin
        n_fail++;
        $display("FAIL capture_busy beat %0d: got %h want %h", b, beat_got, beat_exp);
      end
      n_checks++;
      if (capture_drop_o !== (b == 6)) begin
        n_fail++;
        $display("FAIL capture_drop beat %0d: got %b want %b", b, capture_drop_o, (b == 6));
      end
      if (b == 5) begin
        capture_i = 1'b1;
        drive_tile(1);
      end else begin
        capture_i = 1'b0;
      end
      @(negedge clk_i);
    end
    n_checks++;
    if ({busy_o, capture_drop_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL capture_busy_done: got busy/drop %b want 00", {busy_o, capture_drop_o});
    end
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 16; b++) begin
      tile[b]   = 32'hC000_0000 | 32'(b);
      tile_b[b] = 32'hD000_0000 | 32'(b);
    end
    drive_tile(0);
    out_ready_i = 1'b1;
    capture_i   = 1'b1;
    @(negedge clk_i);
    capture_i = 1'b0;
    for (int b = 0; b < 16; b++) begin
      beat_exp = {1'b1, (b == 15), 4'(b), tile[b]};
      n_checks++;
      if (beat_got !== beat_exp) begin
        n_fail++;
        $display("FAIL b2b_first beat %0d: got %h want %h", b, beat_got, beat_exp);
      end
      if (b == 15) begin
        capture_i = 1'b1;
        drive_tile(1);
      end
      @(negedge clk_i);
    end
    capture_i = 1'b0;
    for (int b = 0; b < 16; b++) begin
      beat_exp = {1'b1, (b == 15), 4'(b), tile_b[b]};
      n_checks++;
      if (beat_got !== beat_exp || capture_drop_o !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_second beat %0d: got %h drop %b want %h drop 0", b, beat_got,
                 capture_drop_o, beat_exp);
      end
      @(negedge clk_i);
    end
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done: got busy %b want 0", busy_o);
    end
  endtask

  task automatic test_reset_mid();
    for (int b = 0; b < 16; b++) begin
      tile[b]   = 32'hE000_0000 | 32'(b);
      tile_b[b] = 32'hF000_0000 | 32'(b);
    end
    drive_tile(0);
    out_ready_i = 1'b1;
    capture_i   = 1'b1;
    @(negedge clk_i);
    capture_i = 1'b0;
    for (int b = 0; b < 8; b++) begin
      beat_exp = {1'b1, (b == 15), 4'(b), tile[b]};
      n_checks++;
      if (beat_got !== beat_exp) begin
        n_fail++;
        $display("FAIL reset_mid_pre beat %0d: got %h want %h", b, beat_got, beat_exp);
      end
      if (b < 7) @(negedge clk_i);
    end
    #2;
    reset_i = 1'b1;
    #1;
    n_checks++;
    if (all_outs !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %h want 0", all_outs);
    end
    @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (all_outs !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: got %h want 0", all_outs);
    end
    drive_tile(1);
    capture_i = 1'b1;
    @(negedge clk_i);
    capture_i = 1'b0;
    for (int b = 0; b < 16; b++) begin
      beat_exp = {1'b1, (b == 15), 4'(b), tile_b[b]};
      n_checks++;
      if (beat_got !== beat_exp) begin
        n_fail++;
        $display("FAIL reset_mid_post beat %0d: got %h want %h", b, beat_got, beat_exp);
      end
      @(negedge clk_i);
    end
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_done: got busy %b want 0", busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_full_drain();
    test_backpressure();
    test_capture_busy();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
